// File: rtl/multi_ritc_beam_correlator.sv
// Multi-RITC beam correlator: per-RITC beams over runtime-programmable channel
// delays, reporting the best beam each clock and a windowed peak with trigger.
module multi_ritc_beam_correlator #(
  parameter int unsigned NRITC     = 2,
  parameter int unsigned INBITS    = 3,
  parameter int unsigned DEMUX     = 16,
  parameter int unsigned NBEAM     = 8,
  parameter int unsigned MAX_DELAY = 47,
  parameter int unsigned WINDOW    = 8,
  parameter int unsigned CORRBITS  = 12
) (
  input  logic                            sysclk_i,
  input  logic                            rst_i,
  input  logic [NRITC*3*DEMUX*INBITS-1:0] dat_i,
  input  logic                            cfg_wr_i,
  input  logic                            cfg_rd_i,
  input  logic [7:0]                      cfg_addr_i,
  input  logic [15:0]                     cfg_dat_i,
  output logic [15:0]                     cfg_dat_o,
  output logic [NRITC*CORRBITS-1:0]       max_o,
  output logic [NRITC*$clog2(NBEAM)-1:0]  max_beam_o,
  output logic                            max_valid_o,
  output logic [NRITC*CORRBITS-1:0]       peak_o,
  output logic [NRITC*$clog2(NBEAM)-1:0]  peak_beam_o,
  output logic                            peak_valid_o,
  output logic [NRITC-1:0]                trig_o
);

  localparam int unsigned NCH    = 3*NRITC;
  localparam int unsigned NWORDS = (MAX_DELAY + DEMUX - 1) / DEMUX + 1;
  localparam int unsigned OLD    = (NWORDS - 1) * DEMUX;
  localparam int unsigned HLEN   = NWORDS * DEMUX;
  localparam int unsigned HW     = $clog2(HLEN);
  localparam int unsigned DW     = $clog2(MAX_DELAY + 1);
  localparam int unsigned BW     = $clog2(NBEAM);
  localparam int unsigned SW     = INBITS + 2;
  localparam int unsigned QW     = 2*SW;
  localparam int unsigned L      = 4 + BW;
  localparam int unsigned CW     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [INBITS-1:0] MID = INBITS'(1 << (INBITS-1));

  logic [INBITS-1:0]    hist_q [NCH][OLD];
  logic [INBITS-1:0]    hist_c [NCH][HLEN];
  logic [DW-1:0]        dly_q  [NRITC][NBEAM][3];
  logic [15:0]          thr_q  [NRITC];
  logic [INBITS-1:0]    win_q  [NRITC][NBEAM][3][DEMUX];
  logic signed [SW-1:0] sum_q  [NRITC][NBEAM][DEMUX];
  logic [QW-1:0]        sq_q   [NRITC][NBEAM][DEMUX];
  logic [CORRBITS-1:0]  acc_c  [NRITC][NBEAM];
  logic [CORRBITS-1:0]  cv_q   [BW+1][NRITC][NBEAM];
  logic [BW-1:0]        cb_q   [BW+1][NRITC][NBEAM];
  logic [L-1:0]         vld_q;
  logic [CW-1:0]        wcnt_q;
  logic [CORRBITS-1:0]  run_q  [NRITC];
  logic [BW-1:0]        runb_q [NRITC];
  logic [CORRBITS-1:0]  cand_v [NRITC];
  logic [BW-1:0]        cand_b [NRITC];
  logic [15:0]          rd_c;
  logic [DW-1:0]        wdly;

  function automatic logic [HW-1:0] tap(input int unsigned j, input logic [DW-1:0] d);
    return HW'(OLD + j) - HW'(d);
  endfunction

  function automatic logic signed [SW-1:0] sval(input logic [INBITS-1:0] code);
    return $signed(SW'(code)) - $signed(SW'(MID));
  endfunction

  function automatic logic [QW-1:0] sqr(input logic signed [SW-1:0] s);
    logic signed [QW-1:0] e;
    e = QW'(s);
    return QW'(e * e);
  endfunction

  // Sample index OLD+j is sample j of the word currently on dat_i.
  always_comb begin
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      for (int unsigned k = 0; k < OLD; k++) hist_c[ch][k] = hist_q[ch][k];
      for (int unsigned j = 0; j < DEMUX; j++)
        hist_c[ch][OLD+j] = dat_i[(ch*DEMUX+j)*INBITS +: INBITS];
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      for (int unsigned ch = 0; ch < NCH; ch++)
        for (int unsigned k = 0; k < OLD; k++) hist_q[ch][k] <= MID;
    end else begin
      for (int unsigned ch = 0; ch < NCH; ch++)
        for (int unsigned k = 0; k < OLD; k++) hist_q[ch][k] <= hist_c[ch][k+DEMUX];
    end
  end

  // S1 window select, S2 three-way sum, S3 square
  always_ff @(posedge sysclk_i) begin
    for (int unsigned r = 0; r < NRITC; r++)
      for (int unsigned b = 0; b < NBEAM; b++)
        for (int unsigned j = 0; j < DEMUX; j++) begin
          if (rst_i) begin
            for (int unsigned c = 0; c < 3; c++) win_q[r][b][c][j] <= MID;
            sum_q[r][b][j] <= '0;
            sq_q[r][b][j]  <= '0;
          end else begin
            for (int unsigned c = 0; c < 3; c++)
              win_q[r][b][c][j] <= hist_c[3*r+c][tap(j, dly_q[r][b][c])];
            sum_q[r][b][j] <= sval(win_q[r][b][0][j]) + sval(win_q[r][b][1][j])
                              + sval(win_q[r][b][2][j]);
            sq_q[r][b][j]  <= sqr(sum_q[r][b][j]);
          end
        end
  end

  always_comb begin
    for (int unsigned r = 0; r < NRITC; r++)
      for (int unsigned b = 0; b < NBEAM; b++) begin
        acc_c[r][b] = '0;
        for (int unsigned j = 0; j < DEMUX; j++)
          acc_c[r][b] = acc_c[r][b] + CORRBITS'(sq_q[r][b][j]);
      end
  end

  // Level 0 is the S4 adder-tree register; each further level halves the
  // candidates, the odd (higher) beam winning only when strictly greater.
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s <= BW; s++)
        for (int unsigned r = 0; r < NRITC; r++)
          for (int unsigned i = 0; i < NBEAM; i++) begin
            cv_q[s][r][i] <= '0;
            cb_q[s][r][i] <= '0;
          end
    end else begin
      for (int unsigned r = 0; r < NRITC; r++)
        for (int unsigned b = 0; b < NBEAM; b++) begin
          cv_q[0][r][b] <= acc_c[r][b];
          cb_q[0][r][b] <= BW'(b);
        end
      for (int unsigned s = 1; s <= BW; s++)
        for (int unsigned r = 0; r < NRITC; r++) begin
          for (int unsigned i = 0; i < NBEAM/2; i++) begin
            if (cv_q[s-1][r][2*i+1] > cv_q[s-1][r][2*i]) begin
              cv_q[s][r][i] <= cv_q[s-1][r][2*i+1];
              cb_q[s][r][i] <= cb_q[s-1][r][2*i+1];
            end else begin
              cv_q[s][r][i] <= cv_q[s-1][r][2*i];
              cb_q[s][r][i] <= cb_q[s-1][r][2*i];
            end
          end
          for (int unsigned i = NBEAM/2; i < NBEAM; i++) begin
            cv_q[s][r][i] <= '0;
            cb_q[s][r][i] <= '0;
          end
        end
    end
  end

  always_comb begin
    max_o      = '0;
    max_beam_o = '0;
    for (int unsigned r = 0; r < NRITC; r++) begin
      max_o[r*CORRBITS +: CORRBITS] = cv_q[BW][r][0];
      max_beam_o[r*BW +: BW]        = cb_q[BW][r][0];
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= {vld_q[L-2:0], 1'b1};
  end

  assign max_valid_o = vld_q[L-1];

  // First clock of a window starts fresh from that clock's max.
  always_comb begin
    for (int unsigned r = 0; r < NRITC; r++) begin
      cand_v[r] = run_q[r];
      cand_b[r] = runb_q[r];
      if (wcnt_q == '0 || cv_q[BW][r][0] > run_q[r]) begin
        cand_v[r] = cv_q[BW][r][0];
        cand_b[r] = cb_q[BW][r][0];
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      wcnt_q       <= '0;
      peak_o       <= '0;
      peak_beam_o  <= '0;
      peak_valid_o <= 1'b0;
      trig_o       <= '0;
      for (int unsigned r = 0; r < NRITC; r++) begin
        run_q[r]  <= '0;
        runb_q[r] <= '0;
      end
    end else begin
      peak_valid_o <= 1'b0;
      trig_o       <= '0;
      if (max_valid_o) begin
        if (wcnt_q == CW'(WINDOW-1)) begin
          wcnt_q       <= '0;
          peak_valid_o <= 1'b1;
          for (int unsigned r = 0; r < NRITC; r++) begin
            peak_o[r*CORRBITS +: CORRBITS] <= cand_v[r];
            peak_beam_o[r*BW +: BW]        <= cand_b[r];
            trig_o[r] <= (32'(cand_v[r]) >= 32'(thr_q[r]));
          end
        end else begin
          wcnt_q <= wcnt_q + CW'(1);
          for (int unsigned r = 0; r < NRITC; r++) begin
            run_q[r]  <= cand_v[r];
            runb_q[r] <= cand_b[r];
          end
        end
      end
    end
  end

  assign wdly = (cfg_dat_i > 16'(MAX_DELAY)) ? DW'(MAX_DELAY) : cfg_dat_i[DW-1:0];

  always_comb begin
    rd_c = '0;
    for (int unsigned r = 0; r < NRITC; r++) begin
      for (int unsigned b = 0; b < NBEAM; b++)
        for (int unsigned c = 0; c < 3; c++)
          if ((r*NBEAM*4 + b*4 + c) < 128 && cfg_addr_i == 8'(r*NBEAM*4 + b*4 + c))
            rd_c = 16'(dly_q[r][b][c]);
      if (cfg_addr_i == 8'(128 + r)) rd_c = thr_q[r];
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      cfg_dat_o <= '0;
      for (int unsigned r = 0; r < NRITC; r++) begin
        thr_q[r] <= '1;
        for (int unsigned b = 0; b < NBEAM; b++)
          for (int unsigned c = 0; c < 3; c++) dly_q[r][b][c] <= '0;
      end
    end else begin
      if (cfg_rd_i) cfg_dat_o <= rd_c;
      if (cfg_wr_i) begin
        for (int unsigned r = 0; r < NRITC; r++) begin
          for (int unsigned b = 0; b < NBEAM; b++)
            for (int unsigned c = 0; c < 3; c++)
              if ((r*NBEAM*4 + b*4 + c) < 128 && cfg_addr_i == 8'(r*NBEAM*4 + b*4 + c))
                dly_q[r][b][c] <= wdly;
          if (cfg_addr_i == 8'(128 + r)) thr_q[r] <= cfg_dat_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_ritc_beam_correlator.sv
// Bench for multi_ritc_beam_correlator: directed steps, expected best-beam
// results queued at drive time and checked when they leave the pipeline.
`timescale 1ns/1ps
module tb_multi_ritc_beam_correlator;
  localparam int NRITC = 2, INBITS = 3, DEMUX = 16, NBEAM = 8;
  localparam int MAX_DELAY = 47, WINDOW = 8, CORRBITS = 12;
  localparam int BW = 3, L = 4 + BW, NCH = 3*NRITC, OLD = 48, HLEN = 64;

  logic                            sysclk_i = 1'b0;
  logic                            rst_i;
  logic [NRITC*3*DEMUX*INBITS-1:0] dat_i;
  logic                            cfg_wr_i, cfg_rd_i;
  logic [7:0]                      cfg_addr_i;
  logic [15:0]                     cfg_dat_i, cfg_dat_o;
  logic [NRITC*CORRBITS-1:0]       max_o, peak_o;
  logic [NRITC*BW-1:0]             max_beam_o, peak_beam_o;
  logic                            max_valid_o, peak_valid_o;
  logic [NRITC-1:0]                trig_o;

  multi_ritc_beam_correlator #(
    .NRITC(NRITC), .INBITS(INBITS), .DEMUX(DEMUX), .NBEAM(NBEAM),
    .MAX_DELAY(MAX_DELAY), .WINDOW(WINDOW), .CORRBITS(CORRBITS)
  ) dut (
    .sysclk_i(sysclk_i), .rst_i(rst_i), .dat_i(dat_i),
    .cfg_wr_i(cfg_wr_i), .cfg_rd_i(cfg_rd_i), .cfg_addr_i(cfg_addr_i),
    .cfg_dat_i(cfg_dat_i), .cfg_dat_o(cfg_dat_o),
    .max_o(max_o), .max_beam_o(max_beam_o), .max_valid_o(max_valid_o),
    .peak_o(peak_o), .peak_beam_o(peak_beam_o), .peak_valid_o(peak_valid_o),
    .trig_o(trig_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  typedef struct packed {
    logic [NRITC*CORRBITS-1:0] mx;
    logic [NRITC*BW-1:0]       bm;
  } exp_t;

  exp_t                      sbq[$];
  int                        hm [NCH][HLEN];
  int                        mdly [NRITC][NBEAM][3];
  int                        mthr [NRITC];
  int                        run_v [NRITC], run_b [NRITC];
  int                        wcnt, edges;
  logic [NRITC*CORRBITS-1:0] exp_peak;
  logic [NRITC*BW-1:0]       exp_pbeam;
  logic                      exp_pv;
  logic [NRITC-1:0]          exp_trig;
  logic [15:0]               exp_rd;
  int                        n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < HLEN; k++) hm[ch][k] = 4;
    for (int r = 0; r < NRITC; r++) begin
      mthr[r] = 'hFFFF; run_v[r] = 0; run_b[r] = 0;
      for (int b = 0; b < NBEAM; b++)
        for (int c = 0; c < 3; c++) mdly[r][b][c] = 0;
    end
    wcnt = 0; edges = 0;
    exp_peak = '0; exp_pbeam = '0; exp_pv = 1'b0; exp_trig = '0; exp_rd = '0;
  endtask

  function automatic int rd_model(input int a);
    if (a < 128) begin
      if (a / (NBEAM*4) < NRITC && a % 4 < 3) return mdly[a/(NBEAM*4)][(a/4) % NBEAM][a % 4];
      return 0;
    end
    if (a - 128 < NRITC) return mthr[a-128];
    return 0;
  endfunction

  task automatic wr_model(input int a, input int d);
    if (a < 128) begin
      if (a / (NBEAM*4) < NRITC && a % 4 < 3)
        mdly[a/(NBEAM*4)][(a/4) % NBEAM][a % 4] = (d > MAX_DELAY) ? MAX_DELAY : d;
    end else if (a - 128 < NRITC) mthr[a-128] = d;
  endtask

  // Correlation straight from its definition over the model sample history.
  task automatic push_expected();
    exp_t e;
    int best, bi, corr, s;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int k = 0; k < OLD; k++) hm[ch][k] = hm[ch][k+DEMUX];
      for (int j = 0; j < DEMUX; j++) hm[ch][OLD+j] = int'(dat_i[(ch*DEMUX+j)*INBITS +: INBITS]);
    end
    e = '0;
    for (int r = 0; r < NRITC; r++) begin
      best = -1; bi = 0;
      for (int b = 0; b < NBEAM; b++) begin
        corr = 0;
        for (int j = 0; j < DEMUX; j++) begin
          s = 0;
          for (int c = 0; c < 3; c++) s += hm[3*r+c][OLD+j-mdly[r][b][c]] - 4;
          corr += s*s;
        end
        if (corr > best) begin best = corr; bi = b; end
      end
      e.mx[r*CORRBITS +: CORRBITS] = CORRBITS'(best);
      e.bm[r*BW +: BW] = BW'(bi);
    end
    sbq.push_back(e);
  endtask

  task automatic win_update(input exp_t m);
    int v, bb;
    exp_pv = 1'b0; exp_trig = '0;
    for (int r = 0; r < NRITC; r++) begin
      v  = int'(m.mx[r*CORRBITS +: CORRBITS]);
      bb = int'(m.bm[r*BW +: BW]);
      if (wcnt != 0 && !(v > run_v[r])) begin v = run_v[r]; bb = run_b[r]; end
      if (wcnt == WINDOW-1) begin
        exp_peak[r*CORRBITS +: CORRBITS] = CORRBITS'(v);
        exp_pbeam[r*BW +: BW] = BW'(bb);
        exp_trig[r] = (v >= mthr[r]);
      end else begin
        run_v[r] = v; run_b[r] = bb;
      end
    end
    if (wcnt == WINDOW-1) begin exp_pv = 1'b1; wcnt = 0; end
    else wcnt++;
  endtask

  task automatic tick();
    exp_t m;
    logic rd;
    logic [15:0] rd_next;
    rd = cfg_rd_i;
    rd_next = 16'(rd_model(int'(cfg_addr_i)));
    push_expected();
    if (cfg_wr_i) wr_model(int'(cfg_addr_i), int'(cfg_dat_i));
    @(posedge sysclk_i);
    @(negedge sysclk_i);
    cfg_wr_i = 1'b0; cfg_rd_i = 1'b0;
    edges++;
    if (rd) exp_rd = rd_next;
    chk("cfg_dat", cfg_dat_o, exp_rd);
    chk("max_valid", max_valid_o, edges >= L);
    chk("peak_valid", peak_valid_o, exp_pv);
    chk("peak", peak_o, exp_peak);
    chk("peak_beam", peak_beam_o, exp_pbeam);
    chk("trig", trig_o, exp_trig);
    if (sbq.size() == L) begin
      m = sbq.pop_front();
      chk("max", max_o, m.mx);
      chk("max_beam", max_beam_o, m.bm);
      win_update(m);
    end else begin
      exp_pv = 1'b0; exp_trig = '0;
    end
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1; cfg_wr_i = 1'b0; cfg_rd_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk_i);
      @(negedge sysclk_i);
      chk("rst_max", max_o, 0);
      chk("rst_max_beam", max_beam_o, 0);
      chk("rst_max_valid", max_valid_o, 0);
      chk("rst_peak", peak_o, 0);
      chk("rst_peak_beam", peak_beam_o, 0);
      chk("rst_peak_valid", peak_valid_o, 0);
      chk("rst_trig", trig_o, 0);
      chk("rst_cfg_dat", cfg_dat_o, 0);
    end
    model_reset();
    rst_i = 1'b0;
  endtask

  task automatic set_all(input int code);
    for (int i = 0; i < NCH*DEMUX; i++) dat_i[i*INBITS +: INBITS] = 3'(code);
  endtask

  task automatic set_sample(input int ch, input int j, input int code);
    dat_i[(ch*DEMUX+j)*INBITS +: INBITS] = 3'(code);
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_wr_i = 1'b1; cfg_addr_i = 8'(a); cfg_dat_i = 16'(d);
    tick();
  endtask

  task automatic cfg_read(input int a);
    cfg_rd_i = 1'b1; cfg_addr_i = 8'(a);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    rst_i = 1'b1; cfg_wr_i = 1'b0; cfg_rd_i = 1'b0; cfg_addr_i = '0; cfg_dat_i = '0;
    dat_i = '0;
    model_reset();
    set_all(4);
    do_reset(3);

    // Zero-valued input: max 0 beam 0, pulses every WINDOW clocks, no trigger
    repeat (40) tick();

    // Full-scale input on every channel: all beams tie at 16*81
    cfg_write(8'h80, 1296);
    set_all(7);
    repeat (20) tick();
    chk("full_scale_max", max_o, {12'd1296, 12'd1296});
    chk("full_scale_beam", max_beam_o, 0);

    // Beam 5 delays A=0 B=5 C=10 in both RITCs
    set_all(4);
    for (int r = 0; r < NRITC; r++) begin
      cfg_write(r*NBEAM*4 + 5*4 + 1, 5);
      cfg_write(r*NBEAM*4 + 5*4 + 2, 10);
    end
    repeat (4) tick();
    // Staggered pulse aligns only on beam 5; coincident pulse ties beam 0 at
    // the same value, exercising earliest-wins in the window.
    for (int rep = 0; rep < 3; rep++) begin
      for (int r = 0; r < NRITC; r++) begin
        set_sample(3*r, 10, 7); set_sample(3*r+1, 5, 7); set_sample(3*r+2, 0, 7);
      end
      tick();
      set_all(4);
      repeat (1 + rep) tick();
      for (int r = 0; r < NRITC; r++)
        for (int c = 0; c < 3; c++) set_sample(3*r+c, 10, 7);
      tick();
      set_all(4);
      repeat (4) tick();
    end
    set_all(7); tick(); set_all(4);
    repeat (12) tick();

    // Config space
    cfg_write(4, 60);
    cfg_read(4);
    chk("delay_clamp_rd", cfg_dat_o, 47);
    cfg_write(8'h80, 16'h0200);
    cfg_read(8'h80);
    chk("thr_rd", cfg_dat_o, 16'h0200);
    cfg_read(8'h03);
    chk("pad_rd", cfg_dat_o, 0);
    cfg_read(8'h81);
    chk("thr1_default", cfg_dat_o, 16'hFFFF);
    cfg_wr_i = 1'b1; cfg_rd_i = 1'b1; cfg_addr_i = 8'h81; cfg_dat_i = 16'h0123;
    tick();
    chk("rd_wr_same_old", cfg_dat_o, 16'hFFFF);
    tick();
    chk("rd_hold", cfg_dat_o, 16'hFFFF);
    cfg_read(8'h81);
    chk("rd_wr_same_new", cfg_dat_o, 16'h0123);
    cfg_read(8'h90);
    chk("unmapped_rd", cfg_dat_o, 0);

    // Random traffic with random delays and mid-range thresholds
    cfg_write(8'h80, 250);
    cfg_write(8'h81, 300);
    for (int i = 0; i < 12; i++)
      cfg_write($urandom_range(NRITC*NBEAM*4-1, 0), $urandom_range(63, 0));
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < NCH*DEMUX; k++) dat_i[k*INBITS +: INBITS] = 3'($urandom_range(7, 0));
      tick();
    end

    // Reset partway through a window, then time the next pulse
    for (int i = 0; i < 20 && wcnt != 5; i++) tick();
    do_reset(2);
    cfg_read(8'h80);
    chk("thr_after_reset", cfg_dat_o, 16'hFFFF);
    first = 0;
    for (int i = 2; i <= 40; i++) begin
      tick();
      if (peak_valid_o === 1'b1 && first == 0) first = i;
    end
    chk("pulse_after_reset", first, L + WINDOW);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
